// File: rtl/inst_mem_loader.sv
// Instruction memory with registered fetch port and a byte-wide valid/ready
// program load port. A small FSM sequences clear-on-reset, fetch, and load.
module inst_mem_loader #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] instruction,
  output logic              fetch_valid,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              load_done,
  output logic [ADDR_W:0]   load_count
);

  typedef enum logic [1:0] {S_CLEAR, S_RUN, S_LOAD, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   FULL = (ADDR_W + 1)'(DEPTH);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] clr_ptr, wr_ptr;
  logic              load_acc;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // A restart on the same cycle as a byte wins; the byte is dropped.
  assign load_acc = (state == S_LOAD) && load_valid && !load_start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_CLEAR;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    fetch_valid = 1'b0;
    load_ready  = 1'b0;
    load_done   = 1'b0;
    case (state)
      S_CLEAR: if (clr_ptr == LAST) state_nxt = S_RUN;
      S_RUN: begin
        fetch_valid = 1'b1;
        if (load_start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        load_ready = 1'b1;
        if (load_acc && wr_ptr == LAST) state_nxt = S_DONE;
      end
      S_DONE: begin
        load_done = 1'b1;
        state_nxt = S_RUN;
      end
      default: state_nxt = S_CLEAR;
    endcase
  end

  always_comb begin
    mem_we    = (state == S_CLEAR) || load_acc;
    mem_waddr = (state == S_CLEAR) ? clr_ptr : wr_ptr;
    mem_wdata = (state == S_CLEAR) ? '0 : load_data;
  end

  // Storage is not reset; the CLEAR sweep zeroes it after every reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_ptr     <= '0;
      wr_ptr      <= '0;
      load_count  <= '0;
      instruction <= '0;
    end else begin
      if (state == S_CLEAR) clr_ptr <= clr_ptr + 1'b1;
      instruction <= (state == S_RUN) ? mem[address] : '0;
      if ((state == S_RUN || state == S_LOAD) && load_start) begin
        wr_ptr     <= '0;
        load_count <= '0;
      end else if (load_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (load_count != FULL) load_count <= load_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Randomized scoreboard bench for inst_mem_loader: driver pushes expected
// fetch data, a negedge monitor pops and compares.
module tb_inst_mem_loader;
  localparam int DW = 8;
  localparam int AW = 3;
  localparam int D  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [AW-1:0] address = '0;
  logic [DW-1:0] instruction;
  logic          fetch_valid;
  logic          load_start = 1'b0;
  logic          load_valid = 1'b0;
  logic [DW-1:0] load_data = '0;
  logic          load_ready;
  logic          load_done;
  logic [AW:0]   load_count;

  inst_mem_loader #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .address(address), .instruction(instruction),
    .fetch_valid(fetch_valid), .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_ready(load_ready), .load_done(load_done),
    .load_count(load_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int stamp; logic [DW-1:0] data; logic [AW-1:0] addr;} exp_t;
  exp_t          q[$];
  exp_t          e;
  logic [DW-1:0] mdl_mem [D];
  int            mdl_cnt = 0;
  logic          fv_d = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected fetches become due one edge after the address was driven.
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].stamp < cyc) begin
      e = q.pop_front();
      chk("fetch_valid_at_fetch", {31'd0, fv_d}, 1);
      chk($sformatf("instr_addr%0d", e.addr), {24'd0, instruction}, {24'd0, e.data});
    end
    fv_d = fetch_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string nm, input bit instr_too);
    chk({nm, "_fv"}, {31'd0, fetch_valid}, 0);
    if (instr_too) chk({nm, "_instr"}, {24'd0, instruction}, 0);
  endtask

  task automatic clear_phase(input bit poke_start);
    for (int i = 0; i < D; i++) begin
      chk_idle("clear", 1);
      chk("clear_ready", {31'd0, load_ready}, 0);
      load_start = poke_start && (i == 3);
      tick();
    end
    load_start = 1'b0;
    chk("run_fv", {31'd0, fetch_valid}, 1);
    chk("run_ready", {31'd0, load_ready}, 0);
    chk("run_count", {28'd0, load_count}, mdl_cnt);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    #1;
    chk("rst_instr", {24'd0, instruction}, 0);
    chk("rst_fv", {31'd0, fetch_valid}, 0);
    chk("rst_ready", {31'd0, load_ready}, 0);
    chk("rst_done", {31'd0, load_done}, 0);
    chk("rst_count", {28'd0, load_count}, 0);
    for (int i = 0; i < D; i++) mdl_mem[i] = '0;
    mdl_cnt = 0;
    load_valid = 1'b0;
    load_start = 1'b0;
    tick();
    rst_n = 1'b1;
    clear_phase(1'b1);
  endtask

  task automatic sweep(input int n, input bit rnd, input bit junk);
    logic [AW-1:0] a;
    for (int i = 0; i < n; i++) begin
      a = rnd ? AW'($urandom_range(0, D - 1)) : AW'(i % D);
      address = a;
      q.push_back('{stamp: cyc, data: mdl_mem[a], addr: a});
      if (junk) begin
        load_valid = 1'b1;
        load_data  = 8'hFF;
        chk("junk_ready", {31'd0, load_ready}, 0);
        chk("junk_count", {28'd0, load_count}, mdl_cnt);
      end
      tick();
    end
    load_valid = 1'b0;
    repeat (2) tick();
  endtask

  task automatic load(input bit do_start, input logic [D-1:0][DW-1:0] bytes,
                      input logic [D-1:0][1:0] gaps, input bit poke_done);
    bit first;
    if (do_start) begin
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      chk("start_count", {28'd0, load_count}, 0);
    end
    first = 1'b1;
    for (int i = 0; i < D; i++) begin
      chk("load_ready", {31'd0, load_ready}, 1);
      chk("load_done_early", {31'd0, load_done}, 0);
      chk_idle("load", !first);
      first = 1'b0;
      load_valid = 1'b1;
      load_data  = bytes[i];
      tick();
      load_valid = 1'b0;
      mdl_mem[i] = bytes[i];
      mdl_cnt    = i + 1;
      if (i < D - 1) begin
        chk("load_count", {28'd0, load_count}, mdl_cnt);
        repeat (gaps[i]) begin
          chk("gap_ready", {31'd0, load_ready}, 1);
          chk_idle("gap", 1);
          tick();
        end
      end
    end
    chk("done_pulse", {31'd0, load_done}, 1);
    chk("done_ready", {31'd0, load_ready}, 0);
    chk_idle("done", 1);
    chk("done_count", {28'd0, load_count}, D);
    load_start = poke_done;
    tick();
    load_start = 1'b0;
    chk("after_done_pulse", {31'd0, load_done}, 0);
    chk("after_done_fv", {31'd0, fetch_valid}, 1);
    chk("after_done_ready", {31'd0, load_ready}, 0);
    chk("after_done_count", {28'd0, load_count}, D);
  endtask

  initial begin
    logic [D-1:0][DW-1:0] b;
    logic [D-1:0][1:0]    g;
    #1;
    reset_dut();
    sweep(8, 0, 0);

    for (int i = 0; i < D; i++) b[i] = DW'(8'hC1 + i);
    g = '0;
    g[1] = 2'd1;
    g[4] = 2'd1;
    load(1'b1, b, g, 1'b1);
    sweep(8, 0, 0);

    // restart mid-load
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1;
      load_data  = DW'(8'h11 * (i + 1));
      tick();
      load_valid = 1'b0;
      mdl_mem[i] = DW'(8'h11 * (i + 1));
      chk("pre_restart_count", {28'd0, load_count}, i + 1);
    end
    load_start = 1'b1;
    load_valid = 1'b1;
    load_data  = 8'h44;
    tick();
    load_start = 1'b0;
    load_valid = 1'b0;
    chk("restart_count", {28'd0, load_count}, 0);
    chk("restart_ready", {31'd0, load_ready}, 1);
    for (int i = 0; i < D; i++) b[i] = DW'(8'hA0 + i);
    load(1'b0, b, '0, 1'b0);
    sweep(8, 0, 0);

    // reset in the middle of a load
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      load_valid = 1'b1;
      load_data  = DW'($urandom);
      tick();
    end
    load_valid = 1'b0;
    reset_dut();
    sweep(8, 0, 0);

    for (int i = 0; i < D; i++) b[i] = DW'(8'h50 + i);
    load(1'b1, b, '0, 1'b0);
    sweep(10, 1, 1);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < D; i++) begin
        b[i] = DW'($urandom);
        g[i] = 2'($urandom_range(0, 3));
      end
      load(1'b1, b, g, r[0]);
      sweep(16, 1, 0);
    end

    for (int i = 0; i < 10 && q.size() > 0; i++) tick();
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
8-entry x 8-bit instruction memory that serves the processor's instruction fetch. The processor drives a 3-bit `address`; this block returns the 8-bit `instruction` one cycle later.
A byte-wide valid/ready load port lets a loader (debug switches or a serial front end) rewrite the whole program at run time.
A small FSM sequences the memory through clear-on-reset, serving fetches, and loading.

Parameters:
DATA_W, 8, instruction width in bits
ADDR_W, 3, fetch address width
DEPTH, 8, number of entries; must equal 2**ADDR_W

Ports:
clk  input  1  system clock; all state updates on posedge
rst_n  input  1  reset; asynchronous assert, active-low
address  input  ADDR_W  fetch address from processor
instruction  output  DATA_W  registered fetch data
fetch_valid  output  1  high when `instruction` reflects memory contents (state RUN)
load_start  input  1  single-cycle request to begin a full program load
load_valid  input  1  `load_data` holds a byte to write
load_data  input  DATA_W  program byte
load_ready  output  1  block accepts a byte this cycle
load_done  output  1  one-cycle pulse after the last byte is written
load_count  output  ADDR_W+1  bytes accepted in the current or last load, 0..DEPTH

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to CLEAR; clear pointer clr_ptr=0.
  - Outputs: instruction=0, fetch_valid=0, load_ready=0, load_done=0, load_count=0.
  - Memory contents are not reset directly; CLEAR zeroes them.
- Release is synchronous to clk: the first posedge with rst_n high performs the first CLEAR write.
- State CLEAR:
  - Each cycle: mem[clr_ptr]<=0, clr_ptr++.
  - After DEPTH writes (DEPTH cycles), go to RUN.
  - instruction held 0, fetch_valid=0; load_start, load_valid ignored.
- State RUN:
  - Each cycle: instruction<=mem[address], fetch_valid=1. Read latency is exactly 1 cycle; the address may change every cycle.
  - load_ready=0.
  - load_start=1: go to LOAD, wr_ptr<=0, load_count<=0. The fetch on that same edge still completes.
  - load_valid in RUN is ignored and has no side effect.
- State LOAD:
  - fetch_valid=0, instruction<=0 (opcode 00) every cycle, so the processor never sees a partial program.
  - load_ready=1.
  - On load_valid&&load_ready: mem[wr_ptr]<=load_data, wr_ptr++, load_count++.
  - When the accepted byte is byte DEPTH-1 (load_count reaches DEPTH): go to DONE.
  - load_valid may drop for any number of cycles; no timeout.
  - load_start=1 in LOAD restarts: wr_ptr<=0, load_count<=0. A byte presented on the same cycle is discarded (restart has priority). Earlier written bytes stay in memory until overwritten.
- State DONE (1 cycle):
  - load_done=1, load_ready=0, fetch_valid=0, instruction=0.
  - Next state RUN; the first valid fetch appears on the following edge.
  - load_start in DONE is ignored.
- Pointers: wr_ptr is ADDR_W bits. load_count is ADDR_W+1 bits and saturates at DEPTH; it holds its value through RUN until the next load_start.
- Reset mid-LOAD or mid-CLEAR: immediate return to CLEAR, and all entries zeroed again. A partial load is never visible to the processor.
- Memory is a single-write, single-read register array. No read/write collision is possible because reads are only served in RUN and writes only occur in CLEAR/LOAD.

Test Plan:
- Reset, then release: instruction=0 and fetch_valid=0 for 8 cycles after release. Then fetch_valid=1 and all 8 addresses read 0x00.
- Pulse load_start; send bytes 0xC1..0xC8 with 1-cycle gaps after bytes 2 and 5. Required: load_ready=1 throughout LOAD; load_count steps 1..8; load_done pulses exactly once, one cycle after byte 8; fetch_valid returns next cycle. Sweeping address 0..7 each cycle then returns 0xC1..0xC8, each 1 cycle after its address.
- Restart mid-load: after 3 bytes (0x11,0x22,0x33), pulse load_start together with load_valid on 0x44. Required: 0x44 discarded and load_count=0. Then load 0xA0..0xA7; readback is 0xA0..0xA7.
- Assert rst_n low after 5 bytes of a load: outputs 0 immediately, without waiting for clk. After release and CLEAR, all addresses read 0x00 and load_count=0.
- In RUN, hold load_valid=1 with load_data=0xFF for 10 cycles: memory unchanged, load_ready=0, load_count unchanged.
- load_start during CLEAR and during DONE: ignored. The state sequence is unchanged and no LOAD is entered.
